// File: rtl/cpu_exec_ctrl_if.sv
// Control bundle between decoder/PC side and the execution controller.
// Master drives buttons, decode and breakpoint setup; slave returns commit, state and counters.
interface cpu_exec_ctrl_if #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 run_btn;
  logic                 step_btn;
  logic                 pause_btn;
  logic                 halt_flag;
  logic [PC_WIDTH-1:0]  pc_addr;
  logic                 bp_en;
  logic [PC_WIDTH-1:0]  bp_addr;
  logic                 commit_en;
  logic [1:0]           state;
  logic                 bp_hit;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output run_btn, step_btn, pause_btn, halt_flag, pc_addr, bp_en, bp_addr,
    input  commit_en, state, bp_hit, cycle_count, instr_count
  );

  modport slave (
    input  run_btn, step_btn, pause_btn, halt_flag, pc_addr, bp_en, bp_addr,
    output commit_en, state, bp_hit, cycle_count, instr_count
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Run/step/pause execution controller with one PC breakpoint; gates instruction commit
// and keeps saturating cycle and retired-instruction counters.
module cpu_exec_ctrl #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  cpu_exec_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_d;
  logic [2:0]           r_sync1, r_sync2, r_sync3;  // {pause, step, run}
  logic [2:0]           w_ev;
  logic                 w_run_ev, w_step_ev, w_pause_ev;
  logic                 r_bp_skip, w_bp_skip_d;
  logic                 r_bp_hit, w_bp_hit_d;
  logic                 w_bp_stop, w_active, w_commit;
  logic [PC_WIDTH-1:0]  w_pc, w_bp_pc;
  logic [CNT_WIDTH-1:0] r_cycle_cnt, r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= {ctrl.pause_btn, ctrl.step_btn, ctrl.run_btn};
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_ev       = r_sync2 & ~r_sync3;
  assign w_run_ev   = w_ev[0];
  assign w_step_ev  = w_ev[1];
  assign w_pause_ev = w_ev[2];

  assign w_pc      = ctrl.pc_addr;
  assign w_bp_pc   = ctrl.bp_addr;
  assign w_active  = (r_state == StRun) || (r_state == StStep);
  assign w_bp_stop = (r_state == StRun) && ctrl.bp_en && (w_pc == w_bp_pc) && !r_bp_skip;
  assign w_commit  = w_active && !ctrl.halt_flag && !w_bp_stop && !w_pause_ev;

  always_comb begin
    w_state_d  = r_state;
    w_bp_hit_d = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_pause_ev)     w_state_d = StIdle;
        else if (w_step_ev) w_state_d = StStep;
        else if (w_run_ev)  w_state_d = StRun;
      end
      StRun: begin
        if (ctrl.halt_flag)  w_state_d = StHalted;
        else if (w_pause_ev) w_state_d = StIdle;
        else if (w_bp_stop) begin
          w_state_d  = StIdle;
          w_bp_hit_d = 1'b1;
        end
      end
      StStep: begin
        if (ctrl.halt_flag) w_state_d = StHalted;
        else                w_state_d = StIdle;
      end
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StIdle;
    endcase
  end

  // Skip is armed only for the first RUN cycle so resuming on the breakpoint PC retires it.
  assign w_bp_skip_d = (r_state != StRun) && (w_state_d == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bp_skip   <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bp_skip <= w_bp_skip_d;
      r_bp_hit  <= w_bp_hit_d;
      if (w_active && (r_cycle_cnt != '1)) r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
      if (w_commit && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + CNT_WIDTH'(1);
    end
  end

  assign ctrl.commit_en   = w_commit;
  assign ctrl.state       = r_state;
  assign ctrl.bp_hit      = r_bp_hit;
  assign ctrl.cycle_count = r_cycle_cnt;
  assign ctrl.instr_count = r_instr_cnt;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: scoreboard of expected values checked by immediate
// assertions; a second instance with 4-bit counters covers saturation.
module tb_cpu_exec_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_exec_ctrl_if #(.PC_WIDTH(8), .CNT_WIDTH(16)) bus ();
  cpu_exec_ctrl_if #(.PC_WIDTH(8), .CNT_WIDTH(4))  bus_s ();

  cpu_exec_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  cpu_exec_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(4)) dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus_s)
  );

  // PC model: advances only on commit, as the real PC register would.
  logic [7:0] pc;
  logic       halt_en;
  logic [7:0] halt_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pc <= '0;
    else if (bus.commit_en) pc <= pc + 8'd1;
  end

  assign bus.pc_addr      = pc;
  assign bus.halt_flag    = halt_en && (pc == halt_pc);
  assign bus_s.pc_addr    = pc;
  assign bus_s.halt_flag  = bus.halt_flag;
  assign bus_s.run_btn    = bus.run_btn;
  assign bus_s.step_btn   = bus.step_btn;
  assign bus_s.pause_btn  = bus.pause_btn;
  assign bus_s.bp_en      = bus.bp_en;
  assign bus_s.bp_addr    = bus.bp_addr;

  // Commit and breakpoint-pulse logs, sampled mid-cycle.
  int commit_pcs[$];
  int bp_hits = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.commit_en) commit_pcs.push_back(int'(pc));
      if (bus.bp_hit)    bp_hits++;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "empty_queue";
      e.val = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    vectors++;
    assert (obs === e.val)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic s, input logic p, input int hold);
    bus.run_btn   = r;
    bus.step_btn  = s;
    bus.pause_btn = p;
    tick(hold);
    bus.run_btn   = 1'b0;
    bus.step_btn  = 1'b0;
    bus.pause_btn = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int cbase;
  int hbase;
  int pc_snap;

  initial begin
    rst_n         = 1'b0;
    bus.run_btn   = 1'b0;
    bus.step_btn  = 1'b0;
    bus.pause_btn = 1'b0;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = '0;
    halt_en       = 1'b0;
    halt_pc       = '0;

    // Reset state
    tick(2);
    sb_push("rst_state", 0);
    sb_push("rst_commit", 0);
    sb_push("rst_bp_hit", 0);
    sb_push("rst_cycle", 0);
    sb_push("rst_instr", 0);
    sb_check(bus.state);
    sb_check(bus.commit_en);
    sb_check(bus.bp_hit);
    sb_check(bus.cycle_count);
    sb_check(bus.instr_count);
    rst_n = 1'b1;
    tick(1);

    // Single step with exact latency, held for 10 cycles
    cbase = commit_pcs.size();
    sb_push("step_edge_k_state", 0);
    sb_push("step_edge_k1_commit", 0);
    sb_push("step_edge_k2_state", 2);
    sb_push("step_edge_k2_commit", 1);
    sb_push("step_edge_k3_state", 0);
    sb_push("step_edge_k3_commit", 0);
    bus.step_btn = 1'b1;
    tick(1); sb_check(bus.state);
    tick(1); sb_check(bus.commit_en);
    tick(1); sb_check(bus.state); sb_check(bus.commit_en);
    tick(1); sb_check(bus.state); sb_check(bus.commit_en);
    tick(6);
    bus.step_btn = 1'b0;
    tick(3);
    sb_push("step1_commits", 1);
    sb_push("step1_pc", 0);
    sb_push("step1_instr", 1);
    sb_push("step1_cycle", 1);
    sb_check(commit_pcs.size() - cbase);
    sb_check(commit_pcs[cbase]);
    sb_check(bus.instr_count);
    sb_check(bus.cycle_count);

    press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 1'b0, 10);
    sb_push("step3_instr", 3);
    sb_push("step3_cycle", 3);
    sb_push("step3_pc", 3);
    sb_push("step3_state", 0);
    sb_check(bus.instr_count);
    sb_check(bus.cycle_count);
    sb_check(pc);
    sb_check(bus.state);

    // Run until HALT at PC 5, then buttons are ignored
    do_reset();
    halt_pc = 8'd5;
    halt_en = 1'b1;
    cbase   = commit_pcs.size();
    press(1'b1, 1'b0, 1'b0, 2);
    tick(10);
    sb_push("halt_state", 3);
    sb_push("halt_commits", 5);
    sb_push("halt_last_pc", 4);
    sb_push("halt_pc", 5);
    sb_push("halt_instr", 5);
    sb_push("halt_cycle", 6);
    sb_check(bus.state);
    sb_check(commit_pcs.size() - cbase);
    sb_check(commit_pcs[commit_pcs.size() - 1]);
    sb_check(pc);
    sb_check(bus.instr_count);
    sb_check(bus.cycle_count);
    press(1'b1, 1'b0, 1'b0, 2);
    press(1'b0, 1'b1, 1'b0, 2);
    press(1'b0, 1'b0, 1'b1, 2);
    sb_push("halted_sticky_state", 3);
    sb_push("halted_commit_en", 0);
    sb_push("halted_commits", 5);
    sb_push("halted_instr", 5);
    sb_check(bus.state);
    sb_check(bus.commit_en);
    sb_check(commit_pcs.size() - cbase);
    sb_check(bus.instr_count);

    // Breakpoint at PC 3, then resume through it
    halt_en = 1'b0;
    do_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'd3;
    cbase = commit_pcs.size();
    hbase = bp_hits;
    press(1'b1, 1'b0, 1'b0, 2);
    tick(10);
    sb_push("bp_state", 0);
    sb_push("bp_pc", 3);
    sb_push("bp_commits", 3);
    sb_push("bp_last_pc", 2);
    sb_push("bp_hit_pulses", 1);
    sb_push("bp_instr", 3);
    sb_push("bp_cycle", 4);
    sb_check(bus.state);
    sb_check(pc);
    sb_check(commit_pcs.size() - cbase);
    sb_check(commit_pcs[commit_pcs.size() - 1]);
    sb_check(bp_hits - hbase);
    sb_check(bus.instr_count);
    sb_check(bus.cycle_count);

    press(1'b1, 1'b0, 1'b0, 2);
    tick(5);
    sb_push("resume_state", 1);
    sb_push("resume_bp_pc_commit", 3);
    sb_push("resume_no_rehit", 1);
    sb_push("resume_progress", 1);
    sb_check(bus.state);
    sb_check(commit_pcs[cbase + 3]);
    sb_check(bp_hits - hbase);
    sb_check(pc > 8'd4);

    // Pause from RUN: the pause-event cycle must not commit
    press(1'b0, 1'b0, 1'b1, 2);
    tick(2);
    sb_push("pause_state", 0);
    sb_push("pause_run_minus_commit", 2);
    sb_push("pause_instr_vs_pc", 32'(pc));
    sb_check(bus.state);
    sb_check(32'(bus.cycle_count) - 32'(bus.instr_count));
    sb_check(bus.instr_count);

    // Step and pause together: pause wins
    pc_snap = int'(pc);
    press(1'b0, 1'b1, 1'b1, 3);
    tick(5);
    sb_push("collide_state", 0);
    sb_push("collide_instr", 32'(pc_snap));
    sb_push("collide_pc", 32'(pc_snap));
    sb_check(bus.state);
    sb_check(bus.instr_count);
    sb_check(pc);

    // Asynchronous reset mid-RUN at cycle_count 37
    bus.bp_en = 1'b0;
    do_reset();
    bus.run_btn = 1'b1;
    for (int i = 0; i < 100 && bus.cycle_count != 16'd37; i++) begin
      tick(1);
      if (i == 2) bus.run_btn = 1'b0;
    end
    bus.run_btn = 1'b0;
    sb_push("midrun_cycle", 37);
    sb_push("midrun_state", 1);
    sb_check(bus.cycle_count);
    sb_check(bus.state);
    rst_n = 1'b0;
    #1;
    sb_push("async_rst_state", 0);
    sb_push("async_rst_commit", 0);
    sb_push("async_rst_cycle", 0);
    sb_push("async_rst_instr", 0);
    sb_check(bus.state);
    sb_check(bus.commit_en);
    sb_check(bus.cycle_count);
    sb_check(bus.instr_count);

    // Saturation on the 4-bit instance
    tick(2);
    rst_n = 1'b1;
    tick(1);
    press(1'b1, 1'b0, 1'b0, 2);
    tick(25);
    sb_push("sat_cycle", 15);
    sb_push("sat_instr", 15);
    sb_push("sat_state", 1);
    sb_push("wide_instr", 32'(pc));
    sb_push("wide_cycle", 32'(pc));
    sb_push("wide_ran_20", 1);
    sb_check(bus_s.cycle_count);
    sb_check(bus_s.instr_count);
    sb_check(bus_s.state);
    sb_check(bus.instr_count);
    sb_check(bus.cycle_count);
    sb_check(pc >= 8'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
